icache_nway: RTL and testbench

ICACHE_NWAY -- requirements
Module: icache_nway

---
 rtl/icache_nway_if.sv | 34 +++
 rtl/icache_nway.sv | 207 ++++++++++++++++++++
 tb/tb_icache_nway.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_nway_if.sv
// Cache-side bundle for icache_nway: CPU fetch port, memory refill port and statistics.
// The cache connects through the slave modport; the CPU/memory side uses master.
interface icache_nway_if;
  logic        cpu_req_valid_i;
  logic [31:0] cpu_req_addr_i;
  logic        cpu_ready_o;
  logic        cpu_res_valid_o;
  logic [31:0] cpu_res_data_o;
  logic        flush_i;
  logic        mem_req_valid_o;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_ready_i;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic [31:0] no_acc_o;
  logic [31:0] no_hit_o;
  logic [31:0] no_miss_o;

  modport slave (
    input  cpu_req_valid_i, cpu_req_addr_i, flush_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    output cpu_ready_o, cpu_res_valid_o, cpu_res_data_o,
           mem_req_valid_o, mem_req_addr_o,
           no_acc_o, no_hit_o, no_miss_o
  );

  modport master (
    output cpu_req_valid_i, cpu_req_addr_i, flush_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    input  cpu_ready_o, cpu_res_valid_o, cpu_res_data_o,
           mem_req_valid_o, mem_req_addr_o,
           no_acc_o, no_hit_o, no_miss_o
  );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with tree-pLRU replacement,
// single-line blocking refill, flush-all and saturating access statistics.
//
// state     | meaning
// S_IDLE    | ready for a request; a pending flush takes priority
// S_LOOKUP  | tag compare; a hit responds in this cycle
// S_MISS_REQ| line refill request held until memory accepts
// S_REFILL  | collecting beats into the victim line
// S_RESPOND | return requested word from the freshly filled line
// S_FLUSH   | clear all valid and pLRU bits
module icache_nway #(
  parameter int WAYS       = 8,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  icache_nway_if.slave bus
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESPOND, S_FLUSH
  } state_t;

  state_t                 state, state_nx;
  logic [31:2]            req_addr;
  logic [WAY_W-1:0]       victim;
  logic [OFF_W-1:0]       beat_cnt;
  logic                   flush_pend;
  logic [SETS-1:0][WAYS-1:0] valid;
  logic [WAYS-2:0]        plru     [SETS];
  logic [TAG_W-1:0]       tag_mem  [SETS][WAYS];
  logic [31:0]            data_mem [SETS][WAYS][LINE_WORDS];
  logic [31:0]            cnt_acc, cnt_hit, cnt_miss;

  logic                   cpu_ready, res_valid, mem_req_valid;
  logic [31:0]            res_data, mem_req_addr;
  logic                   hit, free;
  logic [WAY_W-1:0]       hit_way, free_way, victim_sel;
  logic                   accept, last_beat, beat_in;

  logic [OFF_W-1:0]       req_word;
  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;

  logic unused_byte_bits;
  assign unused_byte_bits = ^bus.cpu_req_addr_i[1:0];

  assign req_word = req_addr[2+:OFF_W];
  assign req_idx  = req_addr[2+OFF_W+:IDX_W];
  assign req_tag  = req_addr[31:TAG_LSB];

  // Heap-ordered tree: node 0 is the root, children of n are 2n+1 / 2n+2.
  // A node bit of 0 sends the victim walk left.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_W:0] node;
    node = '0;
    for (int l = 0; l < WAY_W; l++) begin
      node = (node << 1) + {{WAY_W{1'b0}}, 1'b1} + {{WAY_W{1'b0}}, bits[node[WAY_W-1:0]]};
    end
    return WAY_W'(node - (WAY_W+1)'(WAYS - 1));
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]  b;
    logic [WAY_W:0]   node;
    logic [WAY_W-1:0] sh;
    logic             dir;
    b    = bits;
    node = '0;
    sh   = way;
    for (int l = 0; l < WAY_W; l++) begin
      dir = sh[WAY_W-1];
      sh  = sh << 1;
      b[node[WAY_W-1:0]] = ~dir;
      node = (node << 1) + {{WAY_W{1'b0}}, 1'b1} + {{WAY_W{1'b0}}, dir};
    end
    return b;
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    free     = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[req_idx][w]) begin
        free     = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    victim_sel = free ? free_way : plru_victim(plru[req_idx]);
  end

  always_comb begin
    state_nx      = state;
    cpu_ready     = 1'b0;
    res_valid     = 1'b0;
    res_data      = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (state)
      S_IDLE: begin
        cpu_ready = !flush_pend && !bus.flush_i;
        if (flush_pend || bus.flush_i)   state_nx = S_FLUSH;
        else if (bus.cpu_req_valid_i)    state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          res_valid = 1'b1;
          res_data  = data_mem[req_idx][hit_way][req_word];
          state_nx  = S_IDLE;
        end else begin
          state_nx  = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr[31:2+OFF_W], {(2+OFF_W){1'b0}}};
        if (bus.mem_req_ready_i) state_nx = S_REFILL;
      end
      S_REFILL: begin
        if (bus.mem_rsp_valid_i && beat_cnt == OFF_W'(LINE_WORDS - 1)) state_nx = S_RESPOND;
      end
      S_RESPOND: begin
        res_valid = 1'b1;
        res_data  = data_mem[req_idx][victim][req_word];
        state_nx  = S_IDLE;
      end
      S_FLUSH:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign accept    = (state == S_IDLE) && cpu_ready && bus.cpu_req_valid_i;
  assign beat_in   = (state == S_REFILL) && bus.mem_rsp_valid_i;
  assign last_beat = beat_in && (beat_cnt == OFF_W'(LINE_WORDS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      victim     <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      valid      <= '0;
      cnt_acc    <= '0;
      cnt_hit    <= '0;
      cnt_miss   <= '0;
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      state      <= state_nx;
      flush_pend <= bus.flush_i || (flush_pend && state != S_FLUSH);
      if (accept) begin
        req_addr <= bus.cpu_req_addr_i[31:2];
        if (cnt_acc != '1) cnt_acc <= cnt_acc + 32'd1;
      end
      if (state == S_LOOKUP) begin
        if (hit) begin
          plru[req_idx] <= plru_touch(plru[req_idx], hit_way);
          if (cnt_hit != '1) cnt_hit <= cnt_hit + 32'd1;
        end else begin
          victim <= victim_sel;
          if (cnt_miss != '1) cnt_miss <= cnt_miss + 32'd1;
        end
      end
      if (beat_in) beat_cnt <= beat_cnt + 1'b1;
      if (last_beat) begin
        valid[req_idx][victim] <= 1'b1;
        plru[req_idx]          <= plru_touch(plru[req_idx], victim);
      end
      if (state == S_FLUSH) begin
        valid <= '0;
        for (int s = 0; s < SETS; s++) plru[s] <= '0;
      end
    end
  end

  // Line storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (beat_in) begin
      data_mem[req_idx][victim][beat_cnt] <= bus.mem_rsp_data_i;
      if (last_beat) tag_mem[req_idx][victim] <= req_tag;
    end
  end

  assign bus.cpu_ready_o     = cpu_ready;
  assign bus.cpu_res_valid_o = res_valid;
  assign bus.cpu_res_data_o  = res_data;
  assign bus.mem_req_valid_o = mem_req_valid;
  assign bus.mem_req_addr_o  = mem_req_addr;
  assign bus.no_acc_o        = cnt_acc;
  assign bus.no_hit_o        = cnt_hit;
  assign bus.no_miss_o       = cnt_miss;

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: table of fetch vectors plus hand sequences
// for eviction, flush during refill and reset during refill.
module tb_icache_nway;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_nway_if bus();

  icache_nway #(.WAYS(8), .SETS(16), .LINE_WORDS(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] r_data, r_mem_addr;
  int          r_lat;
  bit          r_saw_mem, r_stable, r_overlap, r_timeout;

  typedef struct {
    logic [31:0] addr;
    int          stall;
    int          gap;
    bit          hit;
    logic [31:0] data;
    logic [31:0] maddr;
    logic [31:0] acc;
    logic [31:0] hits;
    logic [31:0] miss;
  } vec_t;

  vec_t vecs [7];

  // Memory image: line L, word w holds 0x90 + 0x10*L[15:8] + w.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int w);
    return 32'h90 + 32'(line[15:8]) * 32'h10 + 32'(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.cpu_req_valid_i = 1'b0;
    bus.cpu_req_addr_i  = '0;
    bus.flush_i         = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one fetch, plays the memory side, returns when cpu_res_valid_o is seen.
  task automatic fetch(input logic [31:0] a, input int stall, input int gap, input int flush_beat);
    int n, cyc, stall_cnt, gap_cnt, beats;
    bit phase, done;
    r_saw_mem = 0; r_stable = 1; r_overlap = 0; r_timeout = 0;
    r_data = '0; r_lat = 0; r_mem_addr = '0;
    @(negedge clk);
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_addr_i  = a;
    n = 0;
    while (!bus.cpu_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      r_timeout = 1;
      bus.cpu_req_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    bus.cpu_req_valid_i = 1'b0;
    cyc = 1; done = 0; stall_cnt = 0; gap_cnt = 0; beats = 0; phase = 0;
    while (!done && cyc < 100) begin
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.flush_i         = 1'b0;
      if (bus.cpu_res_valid_o && bus.mem_req_valid_o) r_overlap = 1;
      if (bus.cpu_res_valid_o) begin
        r_data = bus.cpu_res_data_o;
        r_lat  = cyc;
        done   = 1;
      end else if (bus.mem_req_valid_o) begin
        if (!r_saw_mem) begin
          r_saw_mem  = 1;
          r_mem_addr = bus.mem_req_addr_o;
        end else if (bus.mem_req_addr_o !== r_mem_addr) begin
          r_stable = 0;
        end
        if (stall_cnt < stall) stall_cnt++;
        else begin
          bus.mem_req_ready_i = 1'b1;
          phase = 1;
        end
      end else if (phase && beats < LW) begin
        if (gap_cnt == 0) begin
          bus.mem_rsp_valid_i = 1'b1;
          bus.mem_rsp_data_i  = mem_word(a & 32'hFFFF_FFF0, beats);
          if (beats == flush_beat) bus.flush_i = 1'b1;
          beats++;
          gap_cnt = gap;
        end else begin
          gap_cnt--;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) r_timeout = 1;
  endtask

  initial begin
    int n;
    vecs[0] = '{32'h104, 0, 0, 1'b0, 32'hA1, 32'h100, 1, 0, 1};
    vecs[1] = '{32'h108, 0, 0, 1'b1, 32'hA2, 32'h0,   2, 1, 1};
    vecs[2] = '{32'h20C, 5, 2, 1'b0, 32'hB3, 32'h200, 3, 1, 2};
    vecs[3] = '{32'h100, 0, 0, 1'b1, 32'hA0, 32'h0,   4, 2, 2};
    vecs[4] = '{32'h204, 0, 0, 1'b1, 32'hB1, 32'h0,   5, 3, 2};
    vecs[5] = '{32'h014, 0, 1, 1'b0, 32'h91, 32'h010, 6, 3, 3};
    vecs[6] = '{32'h01C, 0, 0, 1'b1, 32'h93, 32'h0,   7, 4, 3};

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready",     32'(bus.cpu_ready_o), 32'd1);
    chk("rst_res_valid", 32'(bus.cpu_res_valid_o), 32'd0);
    chk("rst_res_data",  bus.cpu_res_data_o, 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_req_valid_o), 32'd0);
    chk("rst_mem_addr",  bus.mem_req_addr_o, 32'd0);
    chk("rst_acc",       bus.no_acc_o, 32'd0);
    chk("rst_hit",       bus.no_hit_o, 32'd0);
    chk("rst_miss",      bus.no_miss_o, 32'd0);

    for (int i = 0; i < 7; i++) begin
      fetch(vecs[i].addr, vecs[i].stall, vecs[i].gap, -1);
      chk($sformatf("v%0d_timeout", i), 32'(r_timeout), 32'd0);
      chk($sformatf("v%0d_data", i), r_data, vecs[i].data);
      chk($sformatf("v%0d_memreq", i), 32'(r_saw_mem), 32'(!vecs[i].hit));
      chk($sformatf("v%0d_overlap", i), 32'(r_overlap), 32'd0);
      if (vecs[i].hit) begin
        chk($sformatf("v%0d_latency", i), 32'(r_lat), 32'd1);
      end else begin
        chk($sformatf("v%0d_mem_addr", i), r_mem_addr, vecs[i].maddr);
        chk($sformatf("v%0d_addr_stable", i), 32'(r_stable), 32'd1);
      end
      @(negedge clk);
      chk($sformatf("v%0d_acc", i), bus.no_acc_o, vecs[i].acc);
      chk($sformatf("v%0d_hits", i), bus.no_hit_o, vecs[i].hits);
      chk($sformatf("v%0d_miss", i), bus.no_miss_o, vecs[i].miss);
    end

    // Eviction: fill all 8 ways of set 0, touch way 0, then force a replacement.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      fetch(32'(k) << 8, 0, 0, -1);
      chk($sformatf("fill%0d_data", k), r_data, 32'h90 + 32'(k) * 32'h10);
      chk($sformatf("fill%0d_miss", k), 32'(r_saw_mem), 32'd1);
    end
    fetch(32'h000, 0, 0, -1);
    chk("ev_hit0_memreq", 32'(r_saw_mem), 32'd0);
    chk("ev_hit0_data", r_data, 32'h90);
    fetch(32'h800, 0, 0, -1);
    chk("ev_800_memreq", 32'(r_saw_mem), 32'd1);
    chk("ev_800_data", r_data, 32'h110);
    fetch(32'h000, 0, 0, -1);
    chk("ev_keep0_memreq", 32'(r_saw_mem), 32'd0);
    chk("ev_keep0_data", r_data, 32'h90);
    @(negedge clk);
    chk("ev_miss", bus.no_miss_o, 32'd9);
    chk("ev_hits", bus.no_hit_o, 32'd2);
    chk("ev_acc",  bus.no_acc_o, 32'd11);

    // Flush pulse in the middle of a refill.
    do_reset();
    fetch(32'h104, 0, 0, 1);
    chk("fl_timeout", 32'(r_timeout), 32'd0);
    chk("fl_data", r_data, 32'hA1);
    @(negedge clk);
    chk("fl_ready_pending", 32'(bus.cpu_ready_o), 32'd0);
    fetch(32'h104, 0, 0, -1);
    chk("fl_refetch_memreq", 32'(r_saw_mem), 32'd1);
    chk("fl_refetch_data", r_data, 32'hA1);
    @(negedge clk);
    chk("fl_acc",  bus.no_acc_o, 32'd2);
    chk("fl_hits", bus.no_hit_o, 32'd0);
    chk("fl_miss", bus.no_miss_o, 32'd2);

    // Reset during beat 2 of a refill of line 0x100.
    do_reset();
    @(negedge clk);
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_addr_i  = 32'h104;
    @(negedge clk);
    bus.cpu_req_valid_i = 1'b0;
    n = 0;
    while (!bus.mem_req_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rr_memreq_seen", 32'(bus.mem_req_valid_o), 32'd1);
    bus.mem_req_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = 32'hA0 + 32'(b);
    end
    rst = 1'b1;
    #1;
    chk("rr_res_valid", 32'(bus.cpu_res_valid_o), 32'd0);
    chk("rr_res_data",  bus.cpu_res_data_o, 32'd0);
    chk("rr_mem_valid", 32'(bus.mem_req_valid_o), 32'd0);
    chk("rr_mem_addr",  bus.mem_req_addr_o, 32'd0);
    chk("rr_acc",       bus.no_acc_o, 32'd0);
    chk("rr_miss",      bus.no_miss_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rsp_data_i = 32'hA3;
    #1;
    chk("rr_ready_after", 32'(bus.cpu_ready_o), 32'd1);
    @(negedge clk);
    bus.mem_rsp_valid_i = 1'b0;
    fetch(32'h104, 0, 0, -1);
    chk("rr_refetch_memreq", 32'(r_saw_mem), 32'd1);
    chk("rr_refetch_addr", r_mem_addr, 32'h100);
    chk("rr_refetch_data", r_data, 32'hA1);
    @(negedge clk);
    chk("rr_acc_after",  bus.no_acc_o, 32'd1);
    chk("rr_miss_after", bus.no_miss_o, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
